// File: rtl/alu_control_stage.sv
// ALU control decode stage: ALUOp/funct -> {sel,binvert,cin,ainvert,illegal}, registered
// through a 2-entry skid buffer with valid/ready on both sides. Optional NOR: ALU_CTRL_NOR_EN.
module alu_control_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             binvert,
    output logic             cin,
    output logic             ainvert,
    output logic             illegal,
    output logic [CNT_W-1:0] op_count
);
    typedef struct packed {
        logic [1:0] sel;
        logic       binvert;
        logic       cin;
        logic       ainvert;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t C_ADD = '{sel: 2'b10, binvert: 1'b0, cin: 1'b0, ainvert: 1'b0, illegal: 1'b0};
    localparam ctrl_t C_SUB = '{sel: 2'b10, binvert: 1'b1, cin: 1'b1, ainvert: 1'b0, illegal: 1'b0};
    localparam ctrl_t C_AND = '{sel: 2'b00, binvert: 1'b0, cin: 1'b0, ainvert: 1'b0, illegal: 1'b0};
    localparam ctrl_t C_OR  = '{sel: 2'b01, binvert: 1'b0, cin: 1'b0, ainvert: 1'b0, illegal: 1'b0};
    localparam ctrl_t C_SLT = '{sel: 2'b11, binvert: 1'b1, cin: 1'b1, ainvert: 1'b0, illegal: 1'b0};
    localparam ctrl_t C_ILL = '{sel: 2'b00, binvert: 1'b0, cin: 1'b0, ainvert: 1'b0, illegal: 1'b1};
`ifdef ALU_CTRL_NOR_EN
    localparam ctrl_t C_NOR = '{sel: 2'b00, binvert: 1'b1, cin: 1'b0, ainvert: 1'b1, illegal: 1'b0};
`endif

    ctrl_t      dec, ent0, ent1;
    logic [1:0] occ, occ_nxt;
    logic       in_ready_q, push, pop;

    always_comb begin
        dec = C_ILL;
        case (alu_op)
            2'b00: dec = C_ADD;
            2'b01: dec = C_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: dec = C_ADD;
                    6'b100010: dec = C_SUB;
                    6'b100100: dec = C_AND;
                    6'b100101: dec = C_OR;
                    6'b101010: dec = C_SLT;
`ifdef ALU_CTRL_NOR_EN
                    6'b100111: dec = C_NOR;
`endif
                    default:   dec = C_ILL;
                endcase
            end
            default: dec = C_ILL;
        endcase
    end

    assign push = in_valid & in_ready_q;
    assign pop  = (occ != 2'd0) & out_ready;

    always_comb begin
        occ_nxt = occ;
        if (push && !pop)      occ_nxt = occ + 2'd1;
        else if (!push && pop) occ_nxt = occ - 2'd1;
    end

    // ent0 is always the head; when the buffer drains it keeps the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0       <= '0;
            ent1       <= '0;
            occ        <= 2'd0;
            in_ready_q <= 1'b1;
            op_count   <= '0;
        end else begin
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
                ent0 <= dec;
            else if (pop && occ == 2'd2)
                ent0 <= ent1;
            if (push && occ == 2'd1 && !pop)
                ent1 <= dec;
            occ        <= occ_nxt;
            in_ready_q <= (occ_nxt != 2'd2);
            if (pop)
                op_count <= op_count + 1'b1;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ != 2'd0);
    assign sel       = ent0.sel;
    assign binvert   = ent0.binvert;
    assign cin       = ent0.cin;
    assign illegal   = ent0.illegal;
`ifdef ALU_CTRL_NOR_EN
    assign ainvert   = ent0.ainvert;
`else
    // without NOR the decode never sets the stored bit; keep the port a hard zero anyway
    assign ainvert   = ent0.ainvert & 1'b0;
`endif
endmodule

// File: tb/tb_alu_control_stage.sv
// Directed bench for alu_control_stage: decode table sweep plus handshake/reset sequences.
module tb_alu_control_stage;
    logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] alu_op, sel;
    logic [5:0] funct;
    logic       binvert, cin, ainvert, illegal;
    logic [7:0] op_count;

    alu_control_stage #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .binvert(binvert), .cin(cin), .ainvert(ainvert), .illegal(illegal),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] fn;
        logic [1:0] sel;
        logic       bi, ci, ai, il;
    } vec_t;

    vec_t v[10];
    int   passed = 0;
    int   total  = 0;
    int   exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    task automatic push(input logic [1:0] op, input logic [5:0] fn);
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = fn;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        v[0] = '{"lw_add",  2'b00, 6'b000000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1] = '{"beq_sub", 2'b01, 6'b111111, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
        v[2] = '{"r_add",   2'b10, 6'b100000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        v[3] = '{"r_sub",   2'b10, 6'b100010, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
        v[4] = '{"r_and",   2'b10, 6'b100100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[5] = '{"r_or",    2'b10, 6'b100101, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        v[6] = '{"r_slt",   2'b10, 6'b101010, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
        v[7] = '{"r_zero",  2'b10, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
        v[8] = '{"op11",    2'b11, 6'b100000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ALU_CTRL_NOR_EN
        v[9] = '{"r_nor",   2'b10, 6'b100111, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        v[9] = '{"r_nor",   2'b10, 6'b100111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_op = 2'b00; funct = 6'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ctrl", {sel, binvert, cin, ainvert, illegal}, 0);
        chk("rst_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // decode sweep with out_ready=1: visible 1 cycle after push, popped on the next edge
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_op = v[i].op; funct = v[i].fn;
            @(posedge clk);
            #1;
            chk({v[i].name, "_valid"},   out_valid, 1);
            chk({v[i].name, "_sel"},     sel, v[i].sel);
            chk({v[i].name, "_binvert"}, binvert, v[i].bi);
            chk({v[i].name, "_cin"},     cin, v[i].ci);
            chk({v[i].name, "_ainvert"}, ainvert, v[i].ai);
            chk({v[i].name, "_illegal"}, illegal, v[i].il);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            exp_cnt++;
            chk({v[i].name, "_count"}, op_count, exp_cnt);
            chk({v[i].name, "_drained"}, out_valid, 0);
        end

        // backpressure: A=and, B=or held while out_ready=0
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100100;
        @(posedge clk);
        #1;
        chk("bp_ready_after_a", in_ready, 1);
        chk("bp_head_a", sel, 2'b00);
        @(negedge clk);
        funct = 6'b100101;
        @(posedge clk);
        #1;
        chk("bp_full", in_ready, 0);
        chk("bp_head_a_held", sel, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_head_a_stable", sel, 2'b00);
        chk("bp_valid_held", out_valid, 1);
        chk("bp_count_held", op_count, exp_cnt);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("bp_head_b", sel, 2'b01);
        chk("bp_ready_after_pop", in_ready, 1);
        chk("bp_count_a", op_count, exp_cnt);
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("bp_empty", out_valid, 0);
        chk("bp_count_b", op_count, exp_cnt);

        // simultaneous push+pop at occupancy 1: D=slt is head, C=sub pushed while D pops
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b101010;
        @(posedge clk);
        #1;
        chk("sim_head_d", sel, 2'b11);
        @(negedge clk);
        out_ready = 1'b1;
        alu_op = 2'b01; funct = 6'b000000;
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("sim_valid", out_valid, 1);
        chk("sim_head_c", {sel, binvert, cin}, {2'b10, 1'b1, 1'b1});
        chk("sim_count", op_count, exp_cnt);
        chk("sim_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt++;
        chk("sim_single_left", out_valid, 0);
        chk("sim_count2", op_count, exp_cnt);

        // async reset with two ops buffered
        @(negedge clk);
        out_ready = 1'b0;
        push(2'b00, 6'b0);
        push(2'b10, 6'b100101);
        chk("rst2_full", in_ready, 0);
        chk("rst2_count_pre", op_count, exp_cnt);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst2_never_emitted", out_valid, 0);
        chk("rst2_count_stays", op_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
